// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Word-addressed 32-bit data memory for the MIPS datapath. Each access is a
//   req/ready transaction. A fixed number of wait states is inserted before the
//   response, so the core can be run against slow memory. Misaligned and
//   out-of-range accesses are flagged with err and have no effect on memory.
//
//   Handshake: req is sampled only while idle (busy=0). On the accepting edge,
//   we/addr/wdata are captured and stay frozen until the access completes.
//   ready is a one-cycle strobe, and rdata/err are valid while it is high.
//   rdata/err then hold until the next commit. busy is high from the cycle
//   after acceptance through the ready cycle. A new acceptance can only happen
//   once the state is back in IDLE.
//
// Ports
//   clk        in   1   clock, rising edge
//   arst_n     in   1   asynchronous active-low reset
//   req        in   1   access request
//   we         in   1   1 = store, 0 = load
//   addr       in   32  byte address
//   wdata      in   32  store data
//   rdata      out  32  load data (0 for stores and errors)
//   ready      out  1   response strobe
//   err        out  1   misaligned / out-of-range access
//   busy       out  1   access in progress
//   dbg_state  out  2   FSM state (0 IDLE, 1 WAIT, 2 RESP)
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cap_we_q;
  logic [31:0] cap_addr_q;
  logic [31:0] cap_wdata_q;
  logic        accept;
  logic        commit;

  logic [31:0] mem [DEPTH];

  // When there are no wait states, the commit happens on the accepting edge
  // itself, before the capture registers are loaded. So the commit takes its
  // operands straight from the ports while idle.
  logic                  com_we;
  logic [31:0]           com_addr;
  logic [31:0]           com_wdata;
  logic                  com_err;
  logic [DEPTH_LOG2-1:0] com_idx;
  logic                  mem_wr;

  always_comb begin
    if (state_q == S_IDLE) begin
      com_we    = we;
      com_addr  = addr;
      com_wdata = wdata;
    end else begin
      com_we    = cap_we_q;
      com_addr  = cap_addr_q;
      com_wdata = cap_wdata_q;
    end
    com_idx = com_addr[DEPTH_LOG2+1:2];
    com_err = (com_addr[1:0] != 2'b00) || (com_addr[31:DEPTH_LOG2+2] != '0);
    // Reset is asserted asynchronously, but the array has no reset. Gating
    // the write keeps a request seen during reset from landing in memory.
    mem_wr  = commit && com_we && !com_err && arst_n;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        // A count of 0 cannot occur here. It is treated like 1 so the FSM
        // can never stall in WAIT.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          cnt_d   = 4'd0;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= 32'd0;
      cap_wdata_q <= 32'd0;
      rdata       <= 32'd0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_we_q    <= we;
        cap_addr_q  <= addr;
        cap_wdata_q <= wdata;
      end
      if (commit) begin
        err   <= com_err;
        rdata <= (com_err || com_we) ? 32'd0 : mem[com_idx];
      end
    end
  end

  // Memory array: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[com_idx] <= com_wdata;
    end
  end

  assign ready     = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder. Two instances share clk/arst_n:
// u_slow uses WAIT_CYCLES=2 and u_fast uses WAIT_CYCLES=0.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  logic        req_s, we_s, ready_s, err_s, busy_s;
  logic [31:0] addr_s, wdata_s, rdata_s;
  logic [1:0]  st_s;
  logic        req_f, we_f, ready_f, err_f, busy_f;
  logic [31:0] addr_f, wdata_f, rdata_f;
  logic [1:0]  st_f;

  data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) u_slow (
    .clk(clk), .arst_n(arst_n), .req(req_s), .we(we_s), .addr(addr_s),
    .wdata(wdata_s), .rdata(rdata_s), .ready(ready_s), .err(err_s),
    .busy(busy_s), .dbg_state(st_s)
  );

  data_mem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .arst_n(arst_n), .req(req_f), .we(we_f), .addr(addr_f),
    .wdata(wdata_f), .rdata(rdata_f), .ready(ready_f), .err(err_f),
    .busy(busy_f), .dbg_state(st_f)
  );

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];  // {err, rdata}

  typedef struct {
    bit          fast;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input bit fast, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input bit e, input logic [31:0] r);
    vec_t v;
    v.fast = fast; v.we = w; v.addr = a; v.wdata = d; v.exp_err = e; v.exp_rdata = r;
    vecs.push_back(v);
  endtask

  // One access. Pushes the expectation, drives req for one edge, then scrambles
  // the inputs while busy and waits (bounded) for ready.
  task automatic access(input bit fast, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit e, input logic [31:0] r);
    logic [32:0] exp;
    int n;
    bit got;
    logic rdy, bsy, er;
    logic [31:0] rd;
    exp_q.push_back({e, r});
    @(negedge clk);
    if (fast) begin req_f = 1'b1; we_f = w; addr_f = a; wdata_f = d; end
    else      begin req_s = 1'b1; we_s = w; addr_s = a; wdata_s = d; end
    @(posedge clk);
    @(negedge clk);
    if (fast) begin req_f = 1'b0; we_f = ~w; addr_f = $urandom; wdata_f = $urandom; end
    else      begin req_s = 1'b0; we_s = ~w; addr_s = $urandom; wdata_s = $urandom; end
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      rdy = fast ? ready_f : ready_s;
      bsy = fast ? busy_f : busy_s;
      if (rdy) got = 1'b1;
      else begin
        chk("busy_wait", {31'd0, bsy}, 32'd1);
        n++;
        @(negedge clk);
      end
    end
    chk(fast ? "latency_fast" : "latency_slow", n, fast ? 32'd0 : 32'd2);
    exp = exp_q.pop_front();
    rd = fast ? rdata_f : rdata_s;
    er = fast ? err_f : err_s;
    if (got) begin
      chk("rdata", rd, exp[31:0]);
      chk("err", {31'd0, er}, {31'd0, exp[32]});
      chk("busy_resp", {31'd0, fast ? busy_f : busy_s}, 32'd1);
    end
    @(negedge clk);
    chk("ready_one_cycle", {31'd0, fast ? ready_f : ready_s}, 32'd0);
    chk("busy_idle", {31'd0, fast ? busy_f : busy_s}, 32'd0);
    chk("rdata_hold", fast ? rdata_f : rdata_s, exp[31:0]);
    chk("err_hold", {31'd0, fast ? err_f : err_s}, {31'd0, exp[32]});
  endtask

  initial begin
    int pulses;
    int last;
    logic [32:0] exp;
    logic [31:0] a, d;

    arst_n = 1'b0;
    req_s = 0; we_s = 0; addr_s = 0; wdata_s = 0;
    req_f = 0; we_f = 0; addr_f = 0; wdata_f = 0;
    #1;
    chk("rst_rdata", rdata_s, 32'd0);
    chk("rst_ready", {31'd0, ready_s}, 32'd0);
    chk("rst_err", {31'd0, err_s}, 32'd0);
    chk("rst_busy", {31'd0, busy_s}, 32'd0);
    chk("rst_state", {30'd0, st_s}, 32'd0);
    chk("rst_fast_busy", {31'd0, busy_f}, 32'd0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Vector table
    add(0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    add(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    add(0, 0, 32'h13, 32'h0, 1, 32'h0);
    add(0, 1, 32'h12, 32'h11111111, 1, 32'h0);
    add(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    add(0, 1, 32'hFC, 32'hCAFEF00D, 0, 32'h0);
    add(0, 0, 32'hFC, 32'h0, 0, 32'hCAFEF00D);
    add(0, 1, 32'h0, 32'h00000A0A, 0, 32'h0);
    add(0, 1, 32'h100, 32'h55555555, 1, 32'h0);
    add(0, 0, 32'h0, 32'h0, 0, 32'h00000A0A);
    add(0, 0, 32'h100, 32'h0, 1, 32'h0);
    add(0, 0, 32'h80000000, 32'h0, 1, 32'h0);
    add(0, 1, 32'h20, 32'h0BADC0DE, 0, 32'h0);
    add(1, 1, 32'h04, 32'h00000001, 0, 32'h0);
    add(1, 0, 32'h04, 32'h0, 0, 32'h00000001);
    add(1, 1, 32'h04, 32'h00000002, 0, 32'h0);
    add(1, 0, 32'h04, 32'h0, 0, 32'h00000002);
    add(1, 1, 32'h04, 32'h00000003, 0, 32'h0);
    add(1, 0, 32'h04, 32'h0, 0, 32'h00000003);
    add(1, 0, 32'h13, 32'h0, 1, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].fast, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata);
    end

    // Random store/load pairs and misaligned loads on the fast instance
    for (int i = 0; i < 6; i++) begin
      a = {24'd0, 6'($urandom_range(8, 63)), 2'b00};
      d = $urandom;
      access(1, 1, a, d, 0, 32'h0);
      access(1, 0, a, 32'h0, 0, d);
      access(1, 0, a | 32'($urandom_range(1, 3)), 32'h0, 1, 32'h0);
    end

    // req held high for 20 edges: 5 accepted loads, inputs scrambled while busy
    for (int k = 0; k < 5; k++) exp_q.push_back({1'b0, 32'hDEADBEEF});
    @(negedge clk);
    req_s = 1'b1; we_s = 1'b0; addr_s = 32'h10;
    pulses = 0;
    last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (ready_s) begin
        pulses++;
        if (last >= 0) chk("b2b_spacing", c - last, 32'd4);
        last = c;
        if (exp_q.size() == 0) chk("b2b_extra_ready", 32'd1, 32'd0);
        else begin
          exp = exp_q.pop_front();
          chk("b2b_rdata", rdata_s, exp[31:0]);
          chk("b2b_err", {31'd0, err_s}, {31'd0, exp[32]});
        end
      end
      if (c >= 19) req_s = 1'b0;
      if (busy_s) begin
        we_s = 1'b1; addr_s = $urandom | 32'h1; wdata_s = $urandom;
      end else begin
        we_s = 1'b0; addr_s = 32'h10;
      end
    end
    chk("b2b_pulses", pulses, 32'd5);
    exp_q.delete();
    we_s = 1'b0;
    access(0, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF);

    // Reset during WAIT aborts a store
    @(negedge clk);
    req_s = 1'b1; we_s = 1'b1; addr_s = 32'h20; wdata_s = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_s = 1'b0;
    chk("abort_busy_before", {31'd0, busy_s}, 32'd1);
    arst_n = 1'b0;
    #1;
    chk("abort_rdata", rdata_s, 32'd0);
    chk("abort_ready", {31'd0, ready_s}, 32'd0);
    chk("abort_busy", {31'd0, busy_s}, 32'd0);
    chk("abort_state", {30'd0, st_s}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_no_ready", {31'd0, ready_s}, 32'd0);
    end
    access(0, 0, 32'h20, 32'h0, 0, 32'h0BADC0DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
